// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : shared encodings for the multi-cycle MIPS control unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_IMM_EX   = 4'd9,
      S_IMM_WB   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_cond_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [1:0] pc_source;
      logic [2:0] alu_control;
      logic       instr_done;
      logic       illegal_instr;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder : funct / immediate-opcode to ALU operation and extend mode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FUNCT_W  = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                use_funct,
   output logic [2:0]          alu_op,
   output logic                ext_zero,
   output logic                funct_illegal
);

   always_comb begin
      alu_op        = ALU_ADD;
      ext_zero      = 1'b0;
      funct_illegal = 1'b0;
      if (use_funct) begin
         case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_illegal = 1'b1;
         endcase
      end else begin
         // Logical immediates are zero-extended, arithmetic ones sign-extended
         case (opcode)
            OP_ANDI: begin
               alu_op   = ALU_AND;
               ext_zero = 1'b1;
            end
            OP_ORI: begin
               alu_op   = ALU_OR;
               ext_zero = 1'b1;
            end
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : FSM sequencing fetch/decode/execute/memory/writeback
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W      = 6,
   parameter int FUNCT_W       = 6,
   parameter int ALUCTL_W      = 3,
   parameter int MEM_HANDSHAKE = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                pc_write_cond_ne,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                ext_zero,
   output logic [1:0]          pc_source,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                instr_done,
   output logic                illegal_instr,
   output logic [3:0]          state
);

   state_e     state_q, state_d;
   ctrl_t      w_ctrl, w_out;
   logic       w_ready;
   logic       w_use_funct;
   logic [2:0] w_dec_alu;
   logic       w_dec_ext;
   logic       w_dec_illegal;

   generate
      if (MEM_HANDSHAKE != 0) begin : g_handshake
         assign w_ready = mem_ready;
      end else begin : g_no_handshake
         logic w_unused_ready;
         assign w_unused_ready = mem_ready;
         assign w_ready        = 1'b1;
      end
   endgenerate

   assign w_use_funct = (state_q == S_RTYPE_EX) || (state_q == S_RTYPE_WB);

   alu_decoder #(
      .OPCODE_W (OPCODE_W),
      .FUNCT_W  (FUNCT_W)
   ) u_alu_decoder (
      .opcode        (opcode),
      .funct         (funct),
      .use_funct     (w_use_funct),
      .alu_op        (w_dec_alu),
      .ext_zero      (w_dec_ext),
      .funct_illegal (w_dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      w_ctrl  = '0;
      case (state_q)
         S_FETCH: begin
            w_ctrl.mem_read    = 1'b1;
            w_ctrl.alu_src_b   = SRCB_FOUR;
            w_ctrl.alu_control = ALU_ADD;
            if (w_ready) begin
               w_ctrl.ir_write = 1'b1;
               w_ctrl.pc_write = 1'b1;
               state_d         = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALUOut captures the branch target while the opcode is decoded
            w_ctrl.alu_src_b   = SRCB_IMM_SH;
            w_ctrl.alu_control = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW:                     state_d = S_MEMADR;
               OP_RTYPE:                         state_d = S_RTYPE_EX;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EX;
               OP_J:                             state_d = S_JUMP;
               OP_JAL:                           state_d = S_JAL;
               default: begin
                  w_ctrl.illegal_instr = 1'b1;
                  state_d              = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            w_ctrl.alu_src_a   = 1'b1;
            w_ctrl.alu_src_b   = SRCB_IMM;
            w_ctrl.alu_control = ALU_ADD;
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD: begin
            w_ctrl.mem_read = 1'b1;
            w_ctrl.iord     = 1'b1;
            if (w_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_to_reg = WB_MDR;
            w_ctrl.reg_dst    = REGDST_RT;
            w_ctrl.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_MEMWR: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.iord      = 1'b1;
            if (w_ready) begin
               w_ctrl.instr_done = 1'b1;
               state_d           = S_FETCH;
            end
         end
         S_RTYPE_EX: begin
            w_ctrl.alu_src_a   = 1'b1;
            w_ctrl.alu_src_b   = SRCB_B;
            w_ctrl.alu_control = w_dec_alu;
            if (w_dec_illegal) begin
               w_ctrl.illegal_instr = 1'b1;
               state_d              = S_FETCH;
            end else begin
               state_d = S_RTYPE_WB;
            end
         end
         S_RTYPE_WB: begin
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.reg_dst     = REGDST_RD;
            w_ctrl.mem_to_reg  = WB_ALUOUT;
            w_ctrl.alu_control = w_dec_alu;
            w_ctrl.instr_done  = 1'b1;
            state_d            = S_FETCH;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a        = 1'b1;
            w_ctrl.alu_src_b        = SRCB_B;
            w_ctrl.alu_control      = ALU_SUB;
            w_ctrl.pc_source        = PCSRC_ALUOUT;
            w_ctrl.pc_write_cond    = (opcode == OP_BEQ);
            w_ctrl.pc_write_cond_ne = (opcode == OP_BNE);
            w_ctrl.instr_done       = 1'b1;
            state_d                 = S_FETCH;
         end
         S_IMM_EX: begin
            w_ctrl.alu_src_a   = 1'b1;
            w_ctrl.alu_src_b   = SRCB_IMM;
            w_ctrl.alu_control = w_dec_alu;
            w_ctrl.ext_zero    = w_dec_ext;
            state_d            = S_IMM_WB;
         end
         S_IMM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = REGDST_RT;
            w_ctrl.mem_to_reg = WB_ALUOUT;
            w_ctrl.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_JUMP: begin
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.pc_source  = PCSRC_JUMP;
            w_ctrl.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_JAL: begin
            // PC still holds PC+4 here, so r31 gets the return address
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.pc_source  = PCSRC_JUMP;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = REGDST_RA;
            w_ctrl.mem_to_reg = WB_PC;
            w_ctrl.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign w_out = reset ? '0 : w_ctrl;

   assign pc_write         = w_out.pc_write;
   assign pc_write_cond    = w_out.pc_write_cond;
   assign pc_write_cond_ne = w_out.pc_write_cond_ne;
   assign iord             = w_out.iord;
   assign mem_read         = w_out.mem_read;
   assign mem_write        = w_out.mem_write;
   assign ir_write         = w_out.ir_write;
   assign reg_dst          = w_out.reg_dst;
   assign mem_to_reg       = w_out.mem_to_reg;
   assign reg_write        = w_out.reg_write;
   assign alu_src_a        = w_out.alu_src_a;
   assign alu_src_b        = w_out.alu_src_b;
   assign ext_zero         = w_out.ext_zero;
   assign pc_source        = w_out.pc_source;
   assign alu_control      = ALUCTL_W'(w_out.alu_control);
   assign instr_done       = w_out.instr_done;
   assign illegal_instr    = w_out.illegal_instr;
   assign state            = state_q;

endmodule

`default_nettype wire
